// File: rtl/traffic_seg_display_pkg.sv
// Shared types and constants for the countdown display: converter states,
// channel numbering, seven-segment codes and the two-digit clamp.
package traffic_disp_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} conv_state_t;

  typedef enum logic [2:0] {
    CH_N, CH_E, CH_S, CH_W, CH_NL, CH_EL, CH_SL, CH_WL
  } channel_t;

  localparam int NUM_CH = 8;
  localparam int VAL_W  = 10;
  localparam logic [6:0] CLAMP_MAX = 7'd99;

  localparam logic [7:0] SEG_D0    = 8'h3F;
  localparam logic [7:0] SEG_D1    = 8'h06;
  localparam logic [7:0] SEG_D2    = 8'h5B;
  localparam logic [7:0] SEG_D3    = 8'h4F;
  localparam logic [7:0] SEG_D4    = 8'h66;
  localparam logic [7:0] SEG_D5    = 8'h6D;
  localparam logic [7:0] SEG_D6    = 8'h7D;
  localparam logic [7:0] SEG_D7    = 8'h07;
  localparam logic [7:0] SEG_D8    = 8'h7F;
  localparam logic [7:0] SEG_D9    = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high code; a leading zero on the tens digit is blanked.
  function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic is_tens);
    if (is_tens && digit == 4'd0) return SEG_BLANK;
    case (digit)
      4'd0:    return SEG_D0;
      4'd1:    return SEG_D1;
      4'd2:    return SEG_D2;
      4'd3:    return SEG_D3;
      4'd4:    return SEG_D4;
      4'd5:    return SEG_D5;
      4'd6:    return SEG_D6;
      4'd7:    return SEG_D7;
      4'd8:    return SEG_D8;
      4'd9:    return SEG_D9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_seg_display_if.sv
// Countdown bus from the state/time generator: eight packed 10-bit values plus a strobe.
interface traffic_seg_display_if;
  import traffic_disp_pkg::*;

  logic [NUM_CH*VAL_W-1:0] time_bus;
  logic                    time_valid;

  modport master (output time_bus, output time_valid);
  modport slave  (input  time_bus, input  time_valid);
endinterface

// File: rtl/traffic_seg_display_bcd_conv_seq.sv
// Sequential shift-add-3 converter: one start cycle, then seven shift cycles,
// turning a value clamped to 99 into tens/units BCD digits.
module bcd_conv_seq
  import traffic_disp_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       units
);

  logic [6:0] bin;
  logic [7:0] acc;
  logic [7:0] adj;
  logic [2:0] cnt;
  logic       busy;

  function automatic logic [6:0] clamp99(input logic [VAL_W-1:0] v);
    return (v > VAL_W'(CLAMP_MAX)) ? CLAMP_MAX : v[6:0];
  endfunction

  function automatic logic [7:0] add3(input logic [7:0] a);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (a[7:4] >= 4'd5) ? a[7:4] + 4'd3 : a[7:4];
    lo = (a[3:0] >= 4'd5) ? a[3:0] + 4'd3 : a[3:0];
    return {hi, lo};
  endfunction

  assign adj = add3(acc);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      bin  <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      bin  <= clamp99(value);
      acc  <= '0;
    end else if (busy) begin
      acc  <= {adj[6:0], bin[6]};
      bin  <= {bin[5:0], 1'b0};
      cnt  <= cnt + 3'd1;
      if (cnt == 3'd6) busy <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the final shift.
  assign done  = busy && (cnt == 3'd6);
  assign tens  = acc[7:4];
  assign units = acc[3:0];

endmodule

// File: rtl/traffic_seg_display.sv
// Countdown display: snapshot/pending capture, per-channel BCD conversion into a
// work buffer, atomic commit to the display buffer, and a 16-digit scan driver.
module traffic_seg_display
  import traffic_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  traffic_seg_display_if.slave        countdown,
  output logic [15:0]                 seg_sel,
  output logic [7:0]                  seg_data,
  output logic                        conv_busy,
  output logic                        frame_done
);

  localparam int NUM_DIG = 2 * NUM_CH;
  localparam int BUS_W   = NUM_CH * VAL_W;
  localparam int DIV_W   = $clog2(SCAN_DIV);

  conv_state_t       state;
  channel_t          ch;
  logic [BUS_W-1:0]  snapshot;
  logic [BUS_W-1:0]  pend_bus;
  logic              pending;
  logic [3:0]        work [NUM_DIG];
  logic [3:0]        disp [NUM_DIG];
  logic              conv_done;
  logic [3:0]        conv_tens;
  logic [3:0]        conv_units;
  logic [DIV_W-1:0]  div;
  logic [3:0]        idx;

  function automatic logic [15:0] drive_sel(input logic [15:0] v);
    return SEG_ACTIVE_LOW ? ~v : v;
  endfunction

  function automatic logic [7:0] drive_seg(input logic [7:0] v);
    return SEG_ACTIVE_LOW ? ~v : v;
  endfunction

  bcd_conv_seq u_conv (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .start   (state == LOAD),
    .value   (snapshot[ch*VAL_W +: VAL_W]),
    .done    (conv_done),
    .tens    (conv_tens),
    .units   (conv_units)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      ch         <= CH_N;
      snapshot   <= '0;
      pend_bus   <= '0;
      pending    <= 1'b0;
      work       <= '{default: '0};
      disp       <= '{default: '0};
      conv_busy  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (countdown.time_valid && state != IDLE) begin
        pend_bus <= countdown.time_bus;
        pending  <= 1'b1;
      end
      case (state)
        IDLE: if (countdown.time_valid) begin
          snapshot  <= countdown.time_bus;
          ch        <= CH_N;
          conv_busy <= 1'b1;
          state     <= LOAD;
        end
        LOAD:  state <= SHIFT;
        SHIFT: if (conv_done) state <= STORE;
        STORE: begin
          work[{ch, 1'b0}] <= conv_tens;
          work[{ch, 1'b1}] <= conv_units;
          if (ch == CH_WL) begin
            frame_done <= 1'b1;
            state      <= COMMIT;
          end else begin
            ch    <= channel_t'(ch + 3'd1);
            state <= LOAD;
          end
        end
        COMMIT: begin
          disp <= work;
          // A strobe landing on this cycle is newer than anything pending.
          if (countdown.time_valid || pending) begin
            snapshot <= countdown.time_valid ? countdown.time_bus : pend_bus;
            pending  <= 1'b0;
            ch       <= CH_N;
            state    <= LOAD;
          end else begin
            conv_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select and segment data come from one register stage so they switch together.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div      <= '0;
      idx      <= '0;
      seg_sel  <= drive_sel(16'h0000);
      seg_data <= drive_seg(8'h00);
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= idx + 4'd1;
      end else begin
        div <= div + 1'b1;
      end
      seg_sel  <= drive_sel(16'h0001 << idx);
      seg_data <= drive_seg(seg_encode(disp[idx], ~idx[0]));
    end
  end

endmodule

// File: tb/tb_traffic_seg_display.sv
// Randomized bench for traffic_seg_display with a decimal reference model of the panel.
module tb_traffic_seg_display;

  localparam int SCAN_DIV = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] seg_sel;
  logic [7:0]  seg_data;
  logic        conv_busy;
  logic        frame_done;

  traffic_seg_display_if bus_if ();

  traffic_seg_display #(
    .SCAN_DIV       (SCAN_DIV),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .countdown  (bus_if),
    .seg_sel    (seg_sel),
    .seg_data   (seg_data),
    .conv_busy  (conv_busy),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] seg_tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  int         cur [8];
  int         fr  [4][8];
  logic [7:0] exp_disp [16];
  logic [8:0] mgot [3][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Panel pins for one digit, active-low board.
  function automatic logic [7:0] model_digit(input int val, input bit is_tens);
    int v;
    int d;
    v = (val > 99) ? 99 : val;
    d = is_tens ? v / 10 : v % 10;
    if (is_tens && d == 0) return 8'hFF;
    return ~seg_tbl[d];
  endfunction

  task automatic set_expect();
    for (int k = 0; k < 8; k++) begin
      exp_disp[2*k]   = model_digit(cur[k], 1'b1);
      exp_disp[2*k+1] = model_digit(cur[k], 1'b0);
    end
  endtask

  task automatic load_bus();
    for (int k = 0; k < 8; k++) bus_if.time_bus[10*k +: 10] = 10'(cur[k]);
  endtask

  function automatic int sel_index(input logic [15:0] s);
    logic [15:0] oh;
    for (int i = 0; i < 16; i++) begin
      oh = 16'h0001 << i;
      if (s == ~oh) return i;
    end
    return -1;
  endfunction

  task automatic randomize_cur();
    for (int k = 0; k < 8; k++)
      cur[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 99));
  endtask

  // Called just after a negedge; returns on the negedge of the first busy cycle.
  task automatic strobe();
    load_bus();
    bus_if.time_valid = 1'b1;
    @(negedge sys_clk);
    bus_if.time_valid = 1'b0;
  endtask

  task automatic read_display(input string tag);
    logic [8:0] got [16];
    int i;
    for (int j = 0; j < 16; j++) got[j] = 9'h1FF;
    repeat (70) begin
      @(negedge sys_clk);
      i = sel_index(seg_sel);
      if (i >= 0) got[i] = {1'b0, seg_data};
    end
    for (int j = 0; j < 16; j++)
      check($sformatf("%s_digit%0d", tag, j), 32'(got[j]), 32'({1'b0, exp_disp[j]}));
  endtask

  task automatic run_frame(input string tag);
    int fd_at, nfd, busy_n, first_busy;
    fd_at = -1; nfd = 0; busy_n = 0; first_busy = -1;
    strobe();
    for (int k = 1; k <= 90; k++) begin
      if (k > 1) @(negedge sys_clk);
      if (conv_busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = k;
      end
      if (frame_done) begin
        nfd++;
        if (fd_at < 0) fd_at = k;
      end
    end
    check({tag, "_fd_latency"}, fd_at, 73);
    check({tag, "_fd_count"}, nfd, 1);
    check({tag, "_busy_len"}, busy_n, 73);
    check({tag, "_busy_start"}, first_busy, 1);
    set_expect();
    read_display(tag);
  endtask

  initial begin
    int prev, run, idx, changes, wraps, bad_onehot;
    int nfd, last_fd, busy_n;
    int fd_at [3];

    bus_if.time_valid = 1'b0;
    bus_if.time_bus   = '0;

    // Reset held three cycles.
    repeat (3) begin
      @(negedge sys_clk);
      check("rst_sel", 32'(seg_sel), 32'hFFFF);
      check("rst_data", 32'(seg_data), 32'hFF);
      check("rst_busy", 32'(conv_busy), 0);
      check("rst_fd", 32'(frame_done), 0);
    end
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("post_rst_sel", 32'(seg_sel), 32'hFFFE);
    check("post_rst_data", 32'(seg_data), 32'hFF);
    check("post_rst_busy", 32'(conv_busy), 0);
    for (int k = 0; k < 8; k++) cur[k] = 0;
    set_expect();
    read_display("reset");

    // Scan timing and one-hot select.
    prev = -1; run = 0; changes = 0; wraps = 0; bad_onehot = 0;
    repeat (80) begin
      @(negedge sys_clk);
      idx = sel_index(seg_sel);
      if (idx < 0) bad_onehot++;
      if (idx != prev) begin
        if (prev >= 0 && changes > 0) begin
          check("scan_dwell", run, SCAN_DIV);
          check("scan_step", idx, (prev + 1) % 16);
        end
        if (prev == 15 && idx == 0) wraps++;
        if (prev >= 0) changes++;
        prev = idx;
        run = 1;
      end else begin
        run++;
      end
    end
    check("scan_onehot_errors", bad_onehot, 0);
    check("scan_wrapped", wraps, 1);

    cur = '{27, 60, 27, 60, 30, 90, 30, 90};
    run_frame("pattern");

    randomize_cur();
    cur[0] = 3; cur[1] = 0; cur[2] = 1023;
    run_frame("edges");

    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge sys_clk);
      randomize_cur();
      run_frame($sformatf("rand%0d", r));
    end

    // Back-to-back strobes: first, A (dropped), B pending, C in the COMMIT cycle.
    for (int f = 0; f < 4; f++) begin
      randomize_cur();
      for (int k = 0; k < 8; k++) fr[f][k] = cur[k];
    end
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 16; j++) mgot[f][j] = 9'h1FF;
    for (int k = 0; k < 8; k++) cur[k] = fr[0][k];
    strobe();
    nfd = 0; last_fd = 0;
    for (int f = 0; f < 3; f++) fd_at[f] = -1;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) @(negedge sys_clk);
      bus_if.time_valid = 1'b0;
      if (frame_done) begin
        if (nfd < 3) fd_at[nfd] = k;
        nfd++;
        last_fd = k;
        if (nfd == 2) begin
          for (int c = 0; c < 8; c++) cur[c] = fr[3][c];
          load_bus();
          bus_if.time_valid = 1'b1;
        end
      end
      if (k == 10 || k == 20) begin
        for (int c = 0; c < 8; c++) cur[c] = (k == 10) ? int'($urandom_range(0, 1023)) : fr[1][c];
        load_bus();
        bus_if.time_valid = 1'b1;
      end
      if (nfd >= 1 && nfd <= 3 && k >= last_fd + 3) begin
        idx = sel_index(seg_sel);
        if (idx >= 0) mgot[nfd-1][idx] = {1'b0, seg_data};
      end
    end
    bus_if.time_valid = 1'b0;
    check("multi_fd_count", nfd, 3);
    check("multi_fd1", fd_at[0], 73);
    check("multi_fd2", fd_at[1], 146);
    check("multi_fd3", fd_at[2], 219);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) cur[k] = fr[(f == 2) ? 3 : f][k];
      set_expect();
      for (int j = 0; j < 16; j++)
        check($sformatf("multi_f%0d_digit%0d", f + 1, j), 32'(mgot[f][j]), 32'({1'b0, exp_disp[j]}));
    end

    // Reset in the middle of a conversion aborts it.
    randomize_cur();
    strobe();
    repeat (29) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    nfd = 0; busy_n = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (frame_done) nfd++;
      if (conv_busy) busy_n++;
    end
    check("abort_fd_count", nfd, 0);
    check("abort_busy", busy_n, 0);
    for (int k = 0; k < 8; k++) cur[k] = 0;
    set_expect();
    read_display("abort");
    randomize_cur();
    run_frame("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
